// File: rtl/credit_issuer.sv
// credit_issuer: receiver-side credit return manager for the 8b10b credit-flow-controlled link.
// Optional build macro CREDIT_STATS_EN adds token and timeout-flush counters.
module credit_issuer #(
   parameter int DEPTH    = 16,
   parameter int CNT_BITS = $clog2(DEPTH + 1),
   parameter int BATCH    = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                link_up,
   input  logic                slot_freed,
   input  logic                pkt_rx,
   output logic                tok_valid,
   input  logic                tok_ready,
   output logic [CNT_BITS-1:0] tok_credits,
   output logic [CNT_BITS-1:0] pending,
   output logic [CNT_BITS-1:0] outstanding,
   output logic                err
`ifdef CREDIT_STATS_EN
   ,
   output logic [15:0]         tok_count,
   output logic [15:0]         flush_count
`endif
);

   localparam logic [1:0] ST_DOWN = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_IDLE = 2'd2;
   localparam logic [1:0] ST_SEND = 2'd3;

   localparam int WB       = CNT_BITS + 2;
   localparam int TMR_BITS = $clog2(TIMEOUT + 1);

   localparam logic [CNT_BITS-1:0] ZERO_C   = CNT_BITS'(0);
   localparam logic [CNT_BITS-1:0] DEPTH_C  = CNT_BITS'(DEPTH);
   localparam logic [CNT_BITS-1:0] BATCH_C  = CNT_BITS'(BATCH);
   localparam logic [WB-1:0]       ZERO_W   = WB'(0);
   localparam logic [WB-1:0]       DEPTH_W  = WB'(DEPTH);
   localparam logic [TMR_BITS-1:0] TMR_ZERO = TMR_BITS'(0);
   localparam logic [TMR_BITS-1:0] TMR_ONE  = TMR_BITS'(1);
   localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);

   logic [1:0]          state_r, state_s;
   logic [CNT_BITS-1:0] pending_r, pending_s;
   logic [CNT_BITS-1:0] outstanding_r, outstanding_s;
   logic [CNT_BITS-1:0] tok_credits_r, tok_credits_s;
   logic [TMR_BITS-1:0] timer_r, timer_s;
   logic                tok_valid_r, tok_valid_s;
   logic                err_r, err_s;

   logic                hs_s, dec_s, timeout_s, batch_s, cnt_err_s;
   logic [WB-1:0]       give_w_s, pend_w_s, out_w_s;
   logic [CNT_BITS-1:0] pend_sat_s, out_sat_s;

   // Wide next-value arithmetic shared by IDLE and SEND; a handshake moves the token's credits.
   assign hs_s       = tok_valid_r & tok_ready;
   assign dec_s      = pkt_rx && (outstanding_r != ZERO_C);
   assign give_w_s   = hs_s ? WB'(tok_credits_r) : ZERO_W;
   assign pend_w_s   = WB'(pending_r) + WB'(slot_freed) - give_w_s;
   assign out_w_s    = WB'(outstanding_r) + give_w_s - WB'(dec_s);
   assign pend_sat_s = (pend_w_s > DEPTH_W) ? DEPTH_C : pend_w_s[CNT_BITS-1:0];
   assign out_sat_s  = (out_w_s > DEPTH_W) ? DEPTH_C : out_w_s[CNT_BITS-1:0];
   assign cnt_err_s  = (slot_freed && (pending_r == DEPTH_C)) ||
                       (pkt_rx && (outstanding_r == ZERO_C)) ||
                       ((pend_w_s + out_w_s) > DEPTH_W);
   assign timeout_s  = (pending_r != ZERO_C) && (timer_r == TMR_LAST);
   assign batch_s    = (pend_sat_s >= BATCH_C);

   // Next-state and next-output logic for the credit FSM.
   always_comb begin
      state_s       = state_r;
      pending_s     = pending_r;
      outstanding_s = outstanding_r;
      tok_credits_s = tok_credits_r;
      timer_s       = timer_r;
      tok_valid_s   = tok_valid_r;
      err_s         = err_r;
      if (!link_up) begin
         state_s       = ST_DOWN;
         pending_s     = ZERO_C;
         outstanding_s = ZERO_C;
         tok_credits_s = ZERO_C;
         timer_s       = TMR_ZERO;
         tok_valid_s   = 1'b0;
         if (((state_r == ST_DOWN) || (state_r == ST_INIT)) && (slot_freed || pkt_rx)) begin
            err_s = 1'b1;
         end else begin
            err_s = err_r;
         end
      end else begin
         case (state_r)
            ST_DOWN: begin
               // err clears on entry to INIT, but events seen on this very edge still count.
               state_s       = ST_INIT;
               tok_valid_s   = 1'b1;
               tok_credits_s = DEPTH_C;
               pending_s     = ZERO_C;
               outstanding_s = ZERO_C;
               timer_s       = TMR_ZERO;
               err_s         = slot_freed | pkt_rx;
            end
            ST_INIT: begin
               if (slot_freed || pkt_rx) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_r;
               end
               if (hs_s) begin
                  state_s       = ST_IDLE;
                  tok_valid_s   = 1'b0;
                  outstanding_s = DEPTH_C;
                  pending_s     = ZERO_C;
                  timer_s       = TMR_ZERO;
               end else begin
                  state_s = ST_INIT;
               end
            end
            ST_IDLE: begin
               pending_s     = pend_sat_s;
               outstanding_s = out_sat_s;
               err_s         = err_r | cnt_err_s;
               if (batch_s || timeout_s) begin
                  state_s       = ST_SEND;
                  tok_valid_s   = 1'b1;
                  tok_credits_s = pend_sat_s;
                  timer_s       = TMR_ZERO;
               end else if (pending_r == ZERO_C) begin
                  timer_s = TMR_ZERO;
               end else begin
                  timer_s = timer_r + TMR_ONE;
               end
            end
            ST_SEND: begin
               pending_s     = pend_sat_s;
               outstanding_s = out_sat_s;
               err_s         = err_r | cnt_err_s;
               timer_s       = TMR_ZERO;
               if (hs_s) begin
                  state_s     = ST_IDLE;
                  tok_valid_s = 1'b0;
               end else begin
                  state_s = ST_SEND;
               end
            end
            default: begin
               state_s       = ST_DOWN;
               tok_valid_s   = 1'b0;
               tok_credits_s = ZERO_C;
               pending_s     = ZERO_C;
               outstanding_s = ZERO_C;
               timer_s       = TMR_ZERO;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r       <= ST_DOWN;
         pending_r     <= ZERO_C;
         outstanding_r <= ZERO_C;
         tok_credits_r <= ZERO_C;
         timer_r       <= TMR_ZERO;
         tok_valid_r   <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         state_r       <= state_s;
         pending_r     <= pending_s;
         outstanding_r <= outstanding_s;
         tok_credits_r <= tok_credits_s;
         timer_r       <= timer_s;
         tok_valid_r   <= tok_valid_s;
         err_r         <= err_s;
      end
   end

   assign tok_valid   = tok_valid_r;
   assign tok_credits = tok_credits_r;
   assign pending     = pending_r;
   assign outstanding = outstanding_r;
   assign err         = err_r;

`ifdef CREDIT_STATS_EN
   logic [15:0] tok_count_r, flush_count_r;
   logic        tok_evt_s, flush_evt_s;

   // Only INIT and SEND ever offer a token; a flush is a timeout launch that a batch did not cause.
   assign tok_evt_s   = link_up && hs_s;
   assign flush_evt_s = link_up && (state_r == ST_IDLE) && timeout_s && !batch_s;

   // Saturating statistics counters, cleared whenever the link is down.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tok_count_r   <= 16'h0000;
         flush_count_r <= 16'h0000;
      end else if (!link_up) begin
         tok_count_r   <= 16'h0000;
         flush_count_r <= 16'h0000;
      end else begin
         if (tok_evt_s && (tok_count_r != 16'hFFFF)) begin
            tok_count_r <= tok_count_r + 16'h0001;
         end else begin
            tok_count_r <= tok_count_r;
         end
         if (flush_evt_s && (flush_count_r != 16'hFFFF)) begin
            flush_count_r <= flush_count_r + 16'h0001;
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

   assign tok_count   = tok_count_r;
   assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_credit_issuer.sv
// Self-checking bench for credit_issuer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural credit model.
module tb_credit_issuer;

   localparam int DEPTH   = 16;
   localparam int CB      = 5;
   localparam int BATCH   = 4;
   localparam int TIMEOUT = 64;

   logic          CLK, nRST, link_up, slot_freed, pkt_rx, tok_ready;
   logic          tok_valid, err;
   logic [CB-1:0] tok_credits, pending, outstanding;
`ifdef CREDIT_STATS_EN
   logic [15:0]   tok_count, flush_count;
`endif

   int tests;
   int fails;

   credit_issuer dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .link_up     (link_up),
      .slot_freed  (slot_freed),
      .pkt_rx      (pkt_rx),
      .tok_valid   (tok_valid),
      .tok_ready   (tok_ready),
      .tok_credits (tok_credits),
      .pending     (pending),
      .outstanding (outstanding),
      .err         (err)
`ifdef CREDIT_STATS_EN
      ,
      .tok_count   (tok_count),
      .flush_count (flush_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural model: link phase flags plus integer credit accounting.
   typedef struct packed {
      int up;        // link trained, initial grant issued or in progress
      int offer;     // a token is being offered
      int init_tok;  // the offered token is the initial full grant
      int pend;
      int outs;
      int timer;
      int cred;
      int err;
   } model_t;

   model_t m;

   function automatic model_t model_next(model_t c, logic lu, logic sf, logic prx, logic rdy);
      model_t n;
      int     give, np, no;
      n = c;
      if (!lu) begin
         if ((c.up == 0 || c.init_tok != 0) && (sf || prx)) n.err = 1;
         n.up = 0; n.offer = 0; n.init_tok = 0; n.pend = 0; n.outs = 0; n.timer = 0; n.cred = 0;
         return n;
      end
      if (c.up == 0) begin
         n.up = 1; n.offer = 1; n.init_tok = 1; n.cred = DEPTH;
         n.pend = 0; n.outs = 0; n.timer = 0;
         n.err = (sf || prx) ? 1 : 0;
         return n;
      end
      if (c.init_tok != 0) begin
         if (sf || prx) n.err = 1;
         if (rdy) begin
            n.outs = DEPTH; n.pend = 0; n.offer = 0; n.init_tok = 0; n.timer = 0;
         end
         return n;
      end
      give = (c.offer != 0 && rdy) ? c.cred : 0;
      if (sf && c.pend == DEPTH) n.err = 1;
      if (prx && c.outs == 0) n.err = 1;
      np = c.pend + (sf ? 1 : 0) - give;
      no = c.outs + give - ((prx && c.outs > 0) ? 1 : 0);
      if (np + no > DEPTH) n.err = 1;
      if (np > DEPTH) np = DEPTH;
      if (no > DEPTH) no = DEPTH;
      if (c.offer != 0) begin
         n.timer = 0;
         if (give != 0) n.offer = 0;
      end else if (np >= BATCH || (c.pend > 0 && c.timer == TIMEOUT - 1)) begin
         n.offer = 1; n.cred = np; n.timer = 0;
      end else begin
         n.timer = (c.pend > 0) ? c.timer + 1 : 0;
      end
      n.pend = np;
      n.outs = no;
      return n;
   endfunction

   // Model advances on the same edge as the DUT; async reset clears it.
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) m <= '0;
      else       m <= model_next(m, link_up, slot_freed, pkt_rx, tok_ready);
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      nRST = 1'b0; link_up = 1'b0; slot_freed = 1'b0; pkt_rx = 1'b0; tok_ready = 1'b0;
      tick(); tick();
      nRST = 1'b1;
      tick();
      tests++; if (tok_valid !== 1'b0) begin fails++; $display("FAIL reset_tok_valid got %0b want 0", tok_valid); end
      tests++; if (tok_credits !== 5'd0) begin fails++; $display("FAIL reset_tok_credits got %0d want 0", tok_credits); end
      tests++; if (pending !== 5'd0) begin fails++; $display("FAIL reset_pending got %0d want 0", pending); end
      tests++; if (outstanding !== 5'd0) begin fails++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err); end
   endtask

   task automatic test_link_init;
      link_up = 1'b1; tok_ready = 1'b1;
      tick();
      tests++; if (tok_valid !== 1'b1 || tok_credits !== 5'd16) begin
         fails++; $display("FAIL init_token got valid=%0b credits=%0d want 1/16", tok_valid, tok_credits); end
      tick();
      tests++; if (tok_valid !== 1'b0 || outstanding !== 5'd16 || pending !== 5'd0 || err !== 1'b0) begin
         fails++; $display("FAIL init_done got v=%0b out=%0d pend=%0d err=%0b want 0/16/0/0",
                           tok_valid, outstanding, pending, err); end
   endtask

   task automatic test_batching;
      pkt_rx = 1'b1;
      repeat (4) tick();
      pkt_rx = 1'b0; slot_freed = 1'b1;
      repeat (3) tick();
      tests++; if (tok_valid !== 1'b0 || pending !== 5'd3) begin
         fails++; $display("FAIL batch_pre got v=%0b pend=%0d want 0/3", tok_valid, pending); end
      tick();
      slot_freed = 1'b0;
      tests++; if (tok_valid !== 1'b1 || tok_credits !== 5'd4 || outstanding !== 5'd12) begin
         fails++; $display("FAIL batch_token got v=%0b cred=%0d out=%0d want 1/4/12", tok_valid, tok_credits, outstanding); end
      tick();
      tests++; if (tok_valid !== 1'b0 || outstanding !== 5'd16 || pending !== 5'd0) begin
         fails++; $display("FAIL batch_done got v=%0b out=%0d pend=%0d want 0/16/0", tok_valid, outstanding, pending); end
   endtask

   task automatic test_backpressure_timeout;
      int n;
      pkt_rx = 1'b1;
      repeat (5) tick();
      pkt_rx = 1'b0; tok_ready = 1'b0; slot_freed = 1'b1;
      tick();
      tick();
      slot_freed = 1'b0;
      n = 1;
      while (tok_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      tests++; if (n != TIMEOUT) begin fails++; $display("FAIL timeout_latency got %0d cycles want %0d", n, TIMEOUT); end
      tests++; if (tok_credits !== 5'd2) begin fails++; $display("FAIL timeout_credits got %0d want 2", tok_credits); end
      slot_freed = 1'b1;
      repeat (3) tick();
      slot_freed = 1'b0;
      tests++; if (tok_valid !== 1'b1 || tok_credits !== 5'd2 || pending !== 5'd5) begin
         fails++; $display("FAIL stall_stable got v=%0b cred=%0d pend=%0d want 1/2/5", tok_valid, tok_credits, pending); end
      tok_ready = 1'b1;
      tick();
      tests++; if (tok_valid !== 1'b0 || pending !== 5'd3 || outstanding !== 5'd13) begin
         fails++; $display("FAIL stall_release got v=%0b pend=%0d out=%0d want 0/3/13", tok_valid, pending, outstanding); end
   endtask

   task automatic test_simultaneous;
      tok_ready = 1'b0; pkt_rx = 1'b1;
      repeat (10) tick();
      pkt_rx = 1'b0; slot_freed = 1'b1;
      tick();
      tests++; if (tok_valid !== 1'b1 || tok_credits !== 5'd4 || outstanding !== 5'd3) begin
         fails++; $display("FAIL simul_setup got v=%0b cred=%0d out=%0d want 1/4/3", tok_valid, tok_credits, outstanding); end
      slot_freed = 1'b1; pkt_rx = 1'b1; tok_ready = 1'b1;
      tick();
      slot_freed = 1'b0; pkt_rx = 1'b0; tok_ready = 1'b0;
      tests++; if (outstanding !== 5'd6 || pending !== 5'd1 || tok_valid !== 1'b0) begin
         fails++; $display("FAIL simul_result got out=%0d pend=%0d v=%0b want 6/1/0", outstanding, pending, tok_valid); end
   endtask

   task automatic test_errors;
      pkt_rx = 1'b1;
      repeat (6) tick();
      tests++; if (err !== 1'b0 || outstanding !== 5'd0) begin
         fails++; $display("FAIL err_pre got err=%0b out=%0d want 0/0", err, outstanding); end
      tick();
      pkt_rx = 1'b0;
      tests++; if (err !== 1'b1 || outstanding !== 5'd0) begin
         fails++; $display("FAIL err_underflow got err=%0b out=%0d want 1/0", err, outstanding); end
      link_up = 1'b0;
      tick();
      tests++; if (err !== 1'b1 || pending !== 5'd0 || outstanding !== 5'd0 || tok_valid !== 1'b0) begin
         fails++; $display("FAIL link_down got err=%0b pend=%0d out=%0d v=%0b want 1/0/0/0", err, pending, outstanding, tok_valid); end
      link_up = 1'b1;
      tick();
      tests++; if (err !== 1'b0 || tok_valid !== 1'b1 || tok_credits !== 5'd16) begin
         fails++; $display("FAIL reinit got err=%0b v=%0b cred=%0d want 0/1/16", err, tok_valid, tok_credits); end
      tok_ready = 1'b1;
      tick();
      tests++; if (outstanding !== 5'd16 || tok_valid !== 1'b0) begin
         fails++; $display("FAIL reinit_done got out=%0d v=%0b want 16/0", outstanding, tok_valid); end
      link_up = 1'b0;
      tick();
      slot_freed = 1'b1;
      tick();
      slot_freed = 1'b0;
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_freed_down got %0b want 1", err); end
   endtask

   task automatic test_reset_mid;
      link_up = 1'b1; tok_ready = 1'b1;
      tick(); tick();
      tok_ready = 1'b0; pkt_rx = 1'b1;
      repeat (4) tick();
      pkt_rx = 1'b0; slot_freed = 1'b1;
      repeat (4) tick();
      slot_freed = 1'b0;
      tests++; if (tok_valid !== 1'b1) begin fails++; $display("FAIL midrst_send got v=%0b want 1", tok_valid); end
      #2 nRST = 1'b0;
      #1;
      tests++; if (tok_valid !== 1'b0 || tok_credits !== 5'd0 || pending !== 5'd0 ||
                   outstanding !== 5'd0 || err !== 1'b0) begin
         fails++; $display("FAIL midrst_async got v=%0b cred=%0d pend=%0d out=%0d err=%0b want all 0",
                           tok_valid, tok_credits, pending, outstanding, err); end
      link_up = 1'b0; tok_ready = 1'b1;
      tick();
      nRST = 1'b1;
      tick();
      tests++; if (tok_valid !== 1'b0 || outstanding !== 5'd0 || pending !== 5'd0) begin
         fails++; $display("FAIL midrst_after got v=%0b out=%0d pend=%0d want 0/0/0", tok_valid, outstanding, pending); end
   endtask

   task automatic test_random;
      logic [CB*3+1:0] exp_v, got_v;
      link_up = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         link_up    = ($urandom_range(0, 299) != 0);
         slot_freed = ($urandom_range(0, 99) < 30);
         pkt_rx     = ($urandom_range(0, 99) < 25);
         tok_ready  = ($urandom_range(0, 99) < 60);
         tick();
         exp_v = {m.offer[0], m.cred[CB-1:0], m.pend[CB-1:0], m.outs[CB-1:0], m.err[0]};
         got_v = {tok_valid, tok_credits, pending, outstanding, err};
         tests++;
         if (got_v !== exp_v) begin
            fails++;
            $display("FAIL random cycle %0d got v=%0b cred=%0d pend=%0d out=%0d err=%0b want v=%0d cred=%0d pend=%0d out=%0d err=%0d",
                     i, tok_valid, tok_credits, pending, outstanding, err, m.offer, m.cred, m.pend, m.outs, m.err);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      nRST = 1'b0; link_up = 1'b0; slot_freed = 1'b0; pkt_rx = 1'b0; tok_ready = 1'b0;
      test_reset();
      test_link_init();
      test_batching();
      test_backpressure_timeout();
      test_simultaneous();
      test_errors();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/credit_issuer.md
Name: credit_issuer

Overview:
- Receiver-side credit manager for the credit-flow-controlled link on the 8b10b encode/decode path.
- Tracks RX buffer slots freed by downstream logic and returns them to the remote transmitter as credit tokens.
- Tokens go through a valid/ready handshake into the TX symbol mux.
- Each token carries the number of credits being returned. The remote end adds that number to its transmit credit counter.

Parameters:
- DEPTH, 16: RX buffer entries. Also the initial credit grant.
- CNT_BITS, $clog2(DEPTH+1): width of all credit fields.
- BATCH, 4: pending credits that trigger an immediate token.
- TIMEOUT, 64: idle cycles with pending>0 before a partial-batch flush.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- link_up  in  1  link trained and symbol-locked. Level signal.
- slot_freed  in  1  one RX buffer entry popped this cycle.
- pkt_rx  in  1  one RX buffer entry filled this cycle (consumes one granted credit).
- tok_valid  out  1  credit token offered.
- tok_ready  in  1  TX mux accepts token.
- tok_credits  out  CNT_BITS  credits carried by the token.
- pending  out  CNT_BITS  freed credits not yet returned.
- outstanding  out  CNT_BITS  credits held by the remote that are not yet consumed.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (nRST=0, asynchronous) puts the block in:
  - state DOWN
  - tok_valid=0, tok_credits=0
  - pending=0, outstanding=0
  - err=0
  - timer=0
- All outputs are registered.
- States: DOWN, INIT, IDLE, SEND.
- link_up=0 in any state:
  - Next state is DOWN. pending, outstanding, timer and tok_valid are cleared on the next edge.
  - An in-flight token is abandoned. err is kept.
- DOWN -> INIT when link_up=1.
- INIT:
  - err is cleared on entry.
  - tok_valid=1, tok_credits=DEPTH.
  - On handshake: outstanding=DEPTH, pending=0, go to IDLE.
  - slot_freed or pkt_rx while in INIT/DOWN sets err and is otherwise ignored.
- IDLE:
  - slot_freed adds 1 to pending.
  - timer increments while pending>0. It is cleared when pending==0.
  - Go to SEND when pending>=BATCH, or when pending>0 and timer==TIMEOUT-1.
  - The transition edge snapshots pending into tok_credits. That edge also counts any slot_freed in that cycle.
- SEND:
  - tok_valid=1. tok_credits stays stable until tok_ready.
  - slot_freed keeps accumulating into pending.
  - On handshake (tok_valid&tok_ready):
    - pending = pending - tok_credits + slot_freed
    - outstanding = outstanding + tok_credits - pkt_rx
    - timer=0, go to IDLE.
  - A token is never sent with tok_credits=0.
- Latency: from the slot_freed cycle that makes pending reach BATCH to tok_valid=1 is 1 cycle.
- pkt_rx handling:
  - pkt_rx decrements outstanding.
  - pkt_rx with outstanding==0 sets err; outstanding stays 0 (no wrap).
  - pkt_rx and slot_freed in the same cycle are independent.
- Overflow checks:
  - slot_freed with pending==DEPTH sets err; pending saturates at DEPTH.
  - If the next value of pending+outstanding exceeds DEPTH, err is set. Counters still update, saturating at DEPTH.
- A handshake and pkt_rx in the same cycle are both applied, e.g. outstanding 3, token 4 -> 6.
- err is sticky. It is cleared only by nRST or by entering INIT.

Optional Feature:
- Macro: CREDIT_STATS_EN.
- When defined, adds two outputs:
  - tok_count (16 bits): number of completed token handshakes, including the INIT token.
  - flush_count (16 bits): number of timeout-triggered tokens.
  - Both saturate at 16'hFFFF, reset to 0 on nRST and on DOWN entry.
- When undefined, neither port nor its counters exists, and behaviour is otherwise identical.

Test Plan:
- Link init:
  - Stimulus: nRST released, link_up=1, tok_ready=1.
  - Response: tok_valid with tok_credits=16 for one cycle, then outstanding=16, pending=0, err=0.
- Batching:
  - Stimulus: after init, 4 pkt_rx then 4 slot_freed on consecutive cycles, tok_ready=1.
  - Response: outstanding 12; tok_valid one cycle after the 4th slot_freed with tok_credits=4; then outstanding=16, pending=0.
- Backpressure and timeout:
  - Stimulus: 2 slot_freed, tok_ready=0.
  - Response: tok_valid rises 64 cycles after pending became nonzero, with tok_credits=2.
  - Stimulus: 3 more slot_freed while stalled.
  - Response: tok_credits stays 2. After ready, pending=3.
- Simultaneous events:
  - Stimulus: outstanding=3 and token of 4 in SEND; handshake, pkt_rx and slot_freed in the same cycle.
  - Response: outstanding=6, pending=1.
- Error cases:
  - Stimulus: pkt_rx with outstanding=0.
  - Response: err=1, outstanding=0.
  - Stimulus: link_up dropped, then raised.
  - Response: err clears on INIT, a fresh 16-credit token is sent.
  - Stimulus: slot_freed while DOWN.
  - Response: err=1.
- Reset mid-operation:
  - Stimulus: nRST asserted while in SEND with tok_valid=1.
  - Response: all outputs 0 asynchronously; no token is completed.
